control_edicion_campos: RTL and testbench
=========================================

# control_edicion_campos

Edit-mode controller for the clock/date configuration datapath. It converts raw push-button levels into the field-select code `contadoresH` and one-cycle `Arriba`/`Abajo` step pulses, with auto-repeat, that drive the per-field BCD counters. It also raises a commit pulse when editing ends. It sits between the button inputs and the bank of field counters; each counter only steps while its code is selected.

## Interface
- `NUM_CAMPOS`, default 6: number of editable fields; codes 1..NUM_CAMPOS, legal range 1..15.
- `REPEAT_DELAY`, default 50_000_000: cycles an up/down button must be held before auto-repeat starts.
- `REPEAT_PERIOD`, default 12_500_000: cycles between auto-repeat pulses.
- `TIMEOUT`, default 1_000_000_000: idle cycles in EDIT before automatic commit.

- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `btn_config`, in, 1: enter/leave edit mode (asynchronous level).
- `btn_izq`, in, 1: previous field (asynchronous level).
- `btn_der`, in, 1: next field (asynchronous level).
- `btn_arriba`, in, 1: increment (asynchronous level).
- `btn_abajo`, in, 1: decrement (asynchronous level).
- `contadoresH`, out, 4: selected field code; 0 means none.
- `Arriba`, out, 1: one-cycle increment pulse.
- `Abajo`, out, 1: one-cycle decrement pulse.
- `modo_config`, out, 1: high while in EDIT.
- `guardar`, out, 1: one-cycle pulse on leaving EDIT, used to commit values to the RTC.

## Operation
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector.
  - Synchronized levels are also used for hold detection and activity detection.
- States: IDLE, EDIT, COMMIT.
- IDLE: `contadoresH`=0, `modo_config`=0. A `btn_config` edge moves to EDIT with `contadoresH`=1. All other buttons are ignored.
- EDIT field selection:
  - `btn_der` edge: field+1, wrapping NUM_CAMPOS→1.
  - `btn_izq` edge: field−1, wrapping 1→NUM_CAMPOS.
- EDIT stepping:
  - `btn_arriba` edge: `Arriba` pulses and the hold counter starts.
  - While `btn_arriba` stays held, the next pulse comes REPEAT_DELAY cycles after the first, then one every REPEAT_PERIOD cycles.
  - `btn_abajo` behaves the same way, producing `Abajo`.
- Priority within a cycle: config edge > izq/der edge > arriba/abajo.
  - A config edge moves to COMMIT. No step pulse and no field change occur in that cycle.
  - A field change clears the hold counter and sets a lock. While locked, no `Arriba`/`Abajo` pulses are produced until both up and down are released.
  - If up and down are held together, no pulses are produced, the hold counter clears, and the lock is set.
- `Arriba` and `Abajo` are never high in the same cycle. Each pulse lasts exactly 1 cycle.
- Timeout:
  - The idle counter clears on any cycle where any synchronized button level is high.
  - The idle counter reaching TIMEOUT−1 moves to COMMIT.
- COMMIT:
  - Lasts exactly 1 cycle with `guardar`=1, `modo_config`=1, and `contadoresH` holding the last field.
  - The next state is IDLE. Buttons are ignored during COMMIT.
- Reset mid-operation: immediately returns to IDLE with all counters cleared. No `guardar` pulse is produced.

## Timing
- Reset values: `contadoresH`=0, `Arriba`=0, `Abajo`=0, `modo_config`=0, `guardar`=0. Synchronizer flops, edge registers, hold counter, idle counter and lock are all 0.
- All outputs are registered.
- Latency: a button first sampled high at clock edge k produces its output effect after edge k+3 (2 synchronizer stages + 1 output register).
- Repeat timing, with the first pulse at cycle t: subsequent pulses at t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Release: pulses stop within 2 cycles of release reaching the synchronizer output. No pulse is produced on release.
- Counter widths are $clog2 of the largest parameter, and counters saturate rather than wrap.

## Structure
- Package `pkg_config_reloj`:
  - Field code constants: CAMPO_NINGUNO=0, CAMPO_HORA=1, CAMPO_MIN=2, CAMPO_SEG=3, CAMPO_AHO=4, CAMPO_MES=5, CAMPO_DIA=6.
  - State encoding for IDLE/EDIT/COMMIT.
- One sub-module `sincronizador_flanco` (2-FF synchronizer + rising-edge detector, outputs `nivel` and `flanco`), instantiated five times.
- Remaining logic (FSM, hold/repeat counter, idle counter) lives in the top module.

## Test plan
Bench parameters for all scenarios: NUM_CAMPOS=6, REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=64.
1. Reset, then a `btn_config` pulse → 3 cycles later `modo_config`=1 and `contadoresH`=1; `Arriba`, `Abajo` and `guardar` stay 0 throughout.
2. In EDIT, 6 separate `btn_der` presses → `contadoresH` reads 2,3,4,5,6,1. Then one `btn_izq` press → 6.
3. Hold `btn_arriba` for 20 cycles → `Arriba` pulses at relative cycles 0, 8, 12, 16. Release → no further pulses; `Abajo` stays 0.
4. Hold `btn_arriba`, then press `btn_abajo` while it is still held → no pulses while both are held. Release only `btn_abajo` → still no pulses (lock). Release all, then press `btn_abajo` → a single `Abajo` pulse.
5. Enter EDIT, select field 4, press nothing for 64 cycles → `guardar`=1 for exactly 1 cycle with `contadoresH`=4, then `contadoresH`=0 and `modo_config`=0.
6. Assert `reset` while in EDIT with `btn_arriba` held → outputs are 0 immediately and no `guardar` pulse occurs. After release of `reset`, with `btn_arriba` still held → no `Arriba` pulse while in IDLE.

Source files
------------

// File: rtl/control_edicion_campos_pkg.sv
// rtl/control_edicion_campos_pkg.sv - field codes, FSM encoding and field-wrap helpers
// Package pkg_config_reloj: shared constants for the clock/date edit controller.
//   CAMPO_* : field select codes driven on contadoresH (0 = no field selected)
//   estado_t: edit controller state encoding
//   campo_siguiente / campo_anterior: wrap-around field navigation
package pkg_config_reloj;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_HORA    = 4'd1;
    localparam logic [3:0] CAMPO_MIN     = 4'd2;
    localparam logic [3:0] CAMPO_SEG     = 4'd3;
    localparam logic [3:0] CAMPO_AHO     = 4'd4;
    localparam logic [3:0] CAMPO_MES     = 4'd5;
    localparam logic [3:0] CAMPO_DIA     = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } estado_t;

    // Next field, wrapping the last field back to the first one.
    function automatic logic [3:0] campo_siguiente(input logic [3:0] campo,
                                                   input logic [3:0] num_campos);
        if (campo >= num_campos)
            return CAMPO_HORA;
        return campo + 4'd1;
    endfunction

    // Previous field, wrapping the first field back to the last one.
    function automatic logic [3:0] campo_anterior(input logic [3:0] campo,
                                                  input logic [3:0] num_campos);
        if (campo <= CAMPO_HORA)
            return num_campos;
        return campo - 4'd1;
    endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// rtl/sincronizador_flanco.sv - 2-FF button synchronizer with registered rising-edge detect
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_boton    : raw asynchronous button level
//   nivel      : synchronized level (registered, aligned with flanco)
//   flanco     : one-cycle pulse on the first cycle nivel is high
module sincronizador_flanco (
    input  logic clk,
    input  logic reset,
    input  logic i_boton,
    output logic nivel,
    output logic flanco
);

    logic r_s1;
    logic r_s2;
    logic r_nivel;
    logic r_flanco;

    // r_nivel is the previous r_s2; registering both the level and the edge
    // keeps them cycle-aligned for the controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_nivel  <= 1'b0;
            r_flanco <= 1'b0;
        end else begin
            r_s1     <= i_boton;
            r_s2     <= r_s1;
            r_nivel  <= r_s2;
            r_flanco <= r_s2 & ~r_nivel;
        end
    end

    assign nivel  = r_nivel;
    assign flanco = r_flanco;

endmodule

// File: rtl/control_edicion_campos.sv
// rtl/control_edicion_campos.sv - edit-mode controller: field select, step pulses with auto-repeat, commit
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   btn_config/izq/der/arriba/abajo  : raw asynchronous button levels
//   contadoresH                      : selected field code (0 = none)
//   Arriba, Abajo                    : one-cycle increment / decrement pulses
//   modo_config                      : high in EDIT and COMMIT
//   guardar                          : one-cycle commit pulse when leaving EDIT
module control_edicion_campos
    import pkg_config_reloj::*;
#(
    parameter int NUM_CAMPOS    = 6,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 12_500_000,
    parameter int TIMEOUT       = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       modo_config,
    output logic       guardar
);

    localparam int MAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int W     = $clog2(MAX_P + 1);

    localparam logic [3:0]   LP_NUM    = NUM_CAMPOS[3:0];
    localparam logic [W-1:0] LP_DELAY  = W'(REPEAT_DELAY);
    localparam logic [W-1:0] LP_PERIOD = W'(REPEAT_PERIOD);
    localparam logic [W-1:0] LP_TMAX   = W'(TIMEOUT - 1);
    localparam logic [W-1:0] LP_UNO    = W'(1);

    // Conditioned buttons: index 0 config, 1 izq, 2 der, 3 arriba, 4 abajo.
    logic [4:0] w_botones;
    logic [4:0] w_nivel;
    logic [4:0] w_flanco;

    assign w_botones = {btn_abajo, btn_arriba, btn_der, btn_izq, btn_config};

    for (genvar g = 0; g < 5; g++) begin : g_sinc
        sincronizador_flanco u_sinc (
            .clk     (clk),
            .reset   (reset),
            .i_boton (w_botones[g]),
            .nivel   (w_nivel[g]),
            .flanco  (w_flanco[g])
        );
    end

    logic w_f_config, w_f_izq, w_f_der, w_f_up, w_f_dn;
    logic w_n_up, w_n_dn, w_actividad;

    assign w_f_config  = w_flanco[0];
    assign w_f_izq     = w_flanco[1];
    assign w_f_der     = w_flanco[2];
    assign w_f_up      = w_flanco[3];
    assign w_f_dn      = w_flanco[4];
    assign w_n_up      = w_nivel[3];
    assign w_n_dn      = w_nivel[4];
    assign w_actividad = |w_nivel;

    estado_t      r_estado;
    logic [3:0]   r_campo;
    logic         r_arriba;
    logic         r_abajo;
    logic         r_modo;
    logic         r_guardar;
    logic [W-1:0] r_hold;     // cycles since the last step pulse; 0 = not repeating
    logic         r_repite;   // first repeat already issued, use the short period
    logic         r_lock;     // steps blocked until both up and down are released
    logic [W-1:0] r_idle;

    logic [W-1:0] w_umbral;
    assign w_umbral = r_repite ? LP_PERIOD : LP_DELAY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= ST_IDLE;
            r_campo   <= CAMPO_NINGUNO;
            r_arriba  <= 1'b0;
            r_abajo   <= 1'b0;
            r_modo    <= 1'b0;
            r_guardar <= 1'b0;
            r_hold    <= '0;
            r_repite  <= 1'b0;
            r_lock    <= 1'b0;
            r_idle    <= '0;
        end else begin
            r_arriba  <= 1'b0;
            r_abajo   <= 1'b0;
            r_guardar <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    r_campo  <= CAMPO_NINGUNO;
                    r_modo   <= 1'b0;
                    r_hold   <= '0;
                    r_repite <= 1'b0;
                    r_lock   <= 1'b0;
                    r_idle   <= '0;
                    if (w_f_config) begin
                        r_estado <= ST_EDIT;
                        r_campo  <= CAMPO_HORA;
                        r_modo   <= 1'b1;
                    end
                end

                ST_EDIT: begin
                    r_modo <= 1'b1;
                    if (w_actividad)
                        r_idle <= '0;
                    else if (r_idle != LP_TMAX)
                        r_idle <= r_idle + LP_UNO;

                    if (w_f_config || r_idle == LP_TMAX) begin
                        r_estado  <= ST_COMMIT;
                        r_guardar <= 1'b1;
                        r_hold    <= '0;
                        r_repite  <= 1'b0;
                    end else if (w_f_der || w_f_izq) begin
                        r_campo  <= w_f_der ? campo_siguiente(r_campo, LP_NUM)
                                            : campo_anterior(r_campo, LP_NUM);
                        r_hold   <= '0;
                        r_repite <= 1'b0;
                        r_lock   <= 1'b1;
                    end else if (w_n_up && w_n_dn) begin
                        r_hold   <= '0;
                        r_repite <= 1'b0;
                        r_lock   <= 1'b1;
                    end else if (r_lock) begin
                        r_hold   <= '0;
                        r_repite <= 1'b0;
                        if (!w_n_up && !w_n_dn)
                            r_lock <= 1'b0;
                    end else if (w_f_up || w_f_dn) begin
                        r_arriba <= w_f_up;
                        r_abajo  <= w_f_dn;
                        r_hold   <= LP_UNO;
                        r_repite <= 1'b0;
                    end else if ((w_n_up || w_n_dn) && r_hold != '0) begin
                        // Only one of up/down can be high here; it owns the repeat.
                        if (r_hold == w_umbral) begin
                            r_arriba <= w_n_up;
                            r_abajo  <= w_n_dn;
                            r_hold   <= LP_UNO;
                            r_repite <= 1'b1;
                        end else begin
                            r_hold <= r_hold + LP_UNO;
                        end
                    end else begin
                        r_hold   <= '0;
                        r_repite <= 1'b0;
                    end
                end

                ST_COMMIT: begin
                    r_estado <= ST_IDLE;
                    r_campo  <= CAMPO_NINGUNO;
                    r_modo   <= 1'b0;
                    r_hold   <= '0;
                    r_repite <= 1'b0;
                    r_lock   <= 1'b0;
                    r_idle   <= '0;
                end

                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    assign contadoresH = r_campo;
    assign Arriba      = r_arriba;
    assign Abajo       = r_abajo;
    assign modo_config = r_modo;
    assign guardar     = r_guardar;

endmodule

// File: tb/tb_control_edicion_campos.sv
// tb/tb_control_edicion_campos.sv - scoreboard bench for control_edicion_campos
module tb_control_edicion_campos;

    localparam int K_CAMPO = 0;
    localparam int K_MODO  = 1;
    localparam int K_UP    = 2;
    localparam int K_DN    = 3;
    localparam int K_GUARD = 4;

    localparam int B_CFG = 0;
    localparam int B_IZQ = 1;
    localparam int B_DER = 2;
    localparam int B_UP  = 3;
    localparam int B_DN  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_cfg = 1'b0, b_izq = 1'b0, b_der = 1'b0, b_up = 1'b0, b_dn = 1'b0;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, modo_config, guardar;

    control_edicion_campos #(
        .NUM_CAMPOS    (6),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .TIMEOUT       (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_config  (b_cfg),
        .btn_izq     (b_izq),
        .btn_der     (b_der),
        .btn_arriba  (b_up),
        .btn_abajo   (b_dn),
        .contadoresH (contadoresH),
        .Arriba      (Arriba),
        .Abajo       (Abajo),
        .modo_config (modo_config),
        .guardar     (guardar)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int gap;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         ncyc = 0;
    int         last_up = 0;
    int         g_cyc = 0;
    int         last_rel = 0;
    int         field = 0;
    logic [3:0] p_campo = 4'd0;
    logic       p_modo = 1'b0;

    task automatic push(input int k, input int v, input int g);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic got_ev(input int k, input int v, input int g);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event at cycle %0d: got kind=%0d val=%0d, required no event", ncyc, k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || (e.gap >= 0 && e.gap != g)) begin
                errors++;
                $display("FAIL event at cycle %0d: got kind=%0d val=%0d gap=%0d required kind=%0d val=%0d gap=%0d",
                         ncyc, k, v, g, e.kind, e.val, e.gap);
            end
        end
    endtask

    // Monitor: turns every visible output change or pulse into an event.
    always @(negedge clk) begin
        ncyc++;
        if (contadoresH != p_campo) got_ev(K_CAMPO, int'(contadoresH), 0);
        if (modo_config != p_modo) got_ev(K_MODO, int'(modo_config), 0);
        if (Arriba || Abajo) begin
            checks++;
            if (Arriba && Abajo) begin
                errors++;
                $display("FAIL both_steps at cycle %0d: got Arriba=1 Abajo=1 required at most one", ncyc);
            end
        end
        if (Arriba) begin
            got_ev(K_UP, 0, ncyc - last_up);
            last_up = ncyc;
        end
        if (Abajo) got_ev(K_DN, 0, 0);
        if (guardar) begin
            g_cyc = ncyc;
            got_ev(K_GUARD, int'(contadoresH), 0);
        end
        p_campo = contadoresH;
        p_modo  = modo_config;
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_CFG:   b_cfg = v;
            B_IZQ:   b_izq = v;
            B_DER:   b_der = v;
            B_UP:    b_up  = v;
            default: b_dn  = v;
        endcase
    endtask

    task automatic press(input int b, input int len);
        @(posedge clk);
        #1 set_btn(b, 1'b1);
        repeat (len) @(posedge clk);
        #1 set_btn(b, 1'b0);
        last_rel = ncyc;
        repeat (8) @(posedge clk);
    endtask

    // Reference model: expected events derived from the button action alone.
    task automatic do_config();
        if (field == 0) begin
            push(K_CAMPO, 1, -1);
            push(K_MODO, 1, -1);
            field = 1;
        end else begin
            push(K_GUARD, field, -1);
            push(K_CAMPO, 0, -1);
            push(K_MODO, 0, -1);
            field = 0;
        end
        press(B_CFG, 2);
    endtask

    task automatic do_move(input bit der);
        if (der) field = (field % 6) + 1;
        else     field = (field == 1) ? 6 : field - 1;
        push(K_CAMPO, field, -1);
        press(der ? B_DER : B_IZQ, 2);
    endtask

    // Held for len cycles: pulses at relative 0, 8, 12, 16, ... below len.
    task automatic do_step(input bit up, input int len);
        push(up ? K_UP : K_DN, 0, -1);
        for (int j = 8, gp = 8; j < len; j += 4) begin
            push(up ? K_UP : K_DN, 0, up ? gp : -1);
            gp = 4;
        end
        press(up ? B_UP : B_DN, len);
    endtask

    task automatic wait_modo0();
        int n;
        n = 0;
        while (modo_config && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("leave_edit_bound", int'(modo_config), 0);
    endtask

    initial begin
        #2;
        chk("rst_campo", int'(contadoresH), 0);
        chk("rst_modo", int'(modo_config), 0);
        chk("rst_arriba", int'(Arriba), 0);
        chk("rst_abajo", int'(Abajo), 0);
        chk("rst_guardar", int'(guardar), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Enter EDIT with latency check.
        push(K_CAMPO, 1, -1);
        push(K_MODO, 1, -1);
        field = 1;
        @(posedge clk);
        #1 b_cfg = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("latency_early_modo", int'(modo_config), 0);
        @(posedge clk);
        #1 chk("latency_modo", int'(modo_config), 1);
        chk("latency_campo", int'(contadoresH), 1);
        b_cfg = 1'b0;
        repeat (8) @(posedge clk);

        // Field navigation with wrap both ways.
        for (int i = 0; i < 6; i++) do_move(1'b1);
        do_move(1'b0);

        // Auto-repeat on a 20-cycle hold.
        do_step(1'b1, 20);

        // Up and down together lock stepping until both are released.
        push(K_UP, 0, -1);
        push(K_DN, 0, -1);
        @(posedge clk);
        #1 b_up = 1'b1;
        repeat (3) @(posedge clk);
        #1 b_dn = 1'b1;
        repeat (10) @(posedge clk);
        #1 b_dn = 1'b0;
        repeat (12) @(posedge clk);
        #1 b_up = 1'b0;
        repeat (6) @(posedge clk);
        press(B_DN, 2);

        do_config();
        wait_modo0();

        // Timeout commit on field 4.
        do_config();
        for (int i = 0; i < 3; i++) do_move(1'b1);
        push(K_GUARD, 4, -1);
        push(K_CAMPO, 0, -1);
        push(K_MODO, 0, -1);
        field = 0;
        wait_modo0();
        chk("timeout_cycles", g_cyc - last_rel, 68);

        // Reset while editing with up held: no commit, no step in IDLE.
        do_config();
        push(K_UP, 0, -1);
        @(posedge clk);
        #1 b_up = 1'b1;
        repeat (5) @(posedge clk);
        push(K_CAMPO, 0, -1);
        push(K_MODO, 0, -1);
        field = 0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_campo", int'(contadoresH), 0);
        chk("midrst_modo", int'(modo_config), 0);
        chk("midrst_arriba", int'(Arriba), 0);
        chk("midrst_guardar", int'(guardar), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 b_up = 1'b0;
        repeat (8) @(posedge clk);

        // Randomized editing sessions.
        for (int it = 0; it < 5; it++) begin
            do_config();
            for (int m = $urandom_range(0, 5); m > 0; m--) do_move(1'($urandom_range(0, 1)));
            for (int s = $urandom_range(1, 3); s > 0; s--)
                do_step(1'($urandom_range(0, 1)), $urandom_range(1, 22));
            do_config();
            wait_modo0();
        end

        repeat (10) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d still expected, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
